// File: rtl/mul_top.sv
// Iterative RV32M multiplier: radix-2 shift-add on operand magnitudes, then sign fix-up.
// Optional ARVI_MUL_EARLY_OUT_EN: a zero operand completes straight through DONE.
`ifndef XLEN
`define XLEN 32
`endif

module mul_top (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_f3,
    input  logic [`XLEN-1:0]  i_rs1,
    input  logic [`XLEN-1:0]  i_rs2,
    output logic [`XLEN-1:0]  o_res,
    output logic              o_done,
    output logic              o_busy
);
    localparam int unsigned W = `XLEN;

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             neg_q, neg_d;
    logic             hi_q, hi_d;
    logic [W-1:0]     res_q, res_d;
    logic             done_q, done_d;

    logic             s1, s2;
    logic [W:0]       sum;
    logic [2*W-1:0]   prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        res_d   = res_q;
        s1      = 1'b0;
        s2      = 1'b0;
        sum     = '0;
        prod    = '0;
        unique case (state_q)
            StIdle: begin
                if (i_start && !i_f3[2]) begin
                    // MUL low half is sign-agnostic, so only MULH/MULHSU see signed operands
                    s1      = i_rs1[W-1] && (i_f3[1:0] == 2'b01 || i_f3[1:0] == 2'b10);
                    s2      = i_rs2[W-1] && (i_f3[1:0] == 2'b01);
                    a_d     = s1 ? -i_rs1 : i_rs1;
                    b_d     = s2 ? -i_rs2 : i_rs2;
                    neg_d   = s1 ^ s2;
                    hi_d    = (i_f3[1:0] != 2'b00);
                    acc_d   = '0;
                    cnt_d   = 5'd31;
                    state_d = StBusy;
`ifdef ARVI_MUL_EARLY_OUT_EN
                    if (i_rs1 == '0 || i_rs2 == '0) begin
                        res_d   = '0;
                        state_d = StDone;
                    end
`endif
                end
            end
            StBusy: begin
                sum   = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
                acc_d = {sum, acc_q[W-1:1]};
                b_d   = b_q >> 1;
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StFix: begin
                prod    = neg_q ? -acc_q : acc_q;
                res_d   = hi_q ? prod[2*W-1:W] : prod[W-1:0];
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion is registered out of DONE, landing 34 cycles after acceptance
    assign done_d = (state_q == StDone);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign o_res  = res_q;
    assign o_done = done_q;
    assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_mul_top.sv
// Directed bench for mul_top: MUL/MULH/MULHSU/MULHU vectors, latency, back-to-back,
// illegal funct3, mid-operation reset and zero operands.
module tb_mul_top;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic        done;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef ARVI_MUL_EARLY_OUT_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 34;
`endif

    mul_top u_dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_start (start),
        .i_f3    (f3),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .o_res   (res),
        .o_done  (done),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for o_done; lat counts edges after the accept edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output logic busy_ok);
        @(negedge clk);
        f3    = op;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        rs1     = $urandom;
        rs2     = $urandom;
        busy_ok = busy;
        lat     = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        r = res;
    endtask

    logic [31:0] r;
    int          lat;
    logic        bok;
    int          n_done;
    int          n_busy;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        f3    = 3'b000;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", {32'b0, res}, 64'h0);
        check("rst_done", {63'b0, done}, 64'h0);
        check("rst_busy", {63'b0, busy}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'd7, 32'd6, r, lat, bok);
        check("mul_7x6", {32'b0, r}, 64'h2A);
        check("mul_lat", 64'(lat), 64'd34);
        check("mul_busy", {63'b0, bok}, 64'h1);

        run_op(3'b001, 32'hFFFF_FFFD, 32'h5, r, lat, bok);
        check("mulh_m3x5", {32'b0, r}, 64'hFFFF_FFFF);
        run_op(3'b000, 32'hFFFF_FFFD, 32'h5, r, lat, bok);
        check("mul_m3x5", {32'b0, r}, 64'hFFFF_FFF1);

        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bok);
        check("mulh_min", {32'b0, r}, 64'h4000_0000);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, r, lat, bok);
        check("mul_min", {32'b0, r}, 64'h0);

        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bok);
        check("mulhsu_ones", {32'b0, r}, 64'hFFFF_FFFF);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bok);
        check("mulhu_ones", {32'b0, r}, 64'hFFFF_FFFE);
        check("mulhu_lat", 64'(lat), 64'd34);

        // Illegal funct3: request is ignored
        @(negedge clk);
        f3     = 3'b100;
        rs1    = 32'd3;
        rs2    = 32'd3;
        start  = 1'b1;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        start = 1'b0;
        check("ill_busy", 64'(n_busy), 64'd0);
        check("ill_done", 64'(n_done), 64'd0);
        check("ill_res", {32'b0, res}, 64'hFFFF_FFFE);

        // Back-to-back: i_start held through completion picks up fresh operands
        @(negedge clk);
        f3    = 3'b000;
        rs1   = 32'd3;
        rs2   = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        rs1 = 32'd5;
        rs2 = 32'd9;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("b2b_lat1", 64'(lat), 64'd34);
        check("b2b_res1", {32'b0, res}, 64'd12);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_restart", {63'b0, busy}, 64'h1);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("b2b_lat2", 64'(lat), 64'd34);
        check("b2b_res2", {32'b0, res}, 64'd45);

        run_op(3'b000, 32'h0, 32'h1234_5678, r, lat, bok);
        check("zero_res", {32'b0, r}, 64'h0);
        check("zero_lat", 64'(lat), 64'(ZeroLat));

        // Reset in the 10th BUSY cycle
        @(negedge clk);
        f3    = 3'b011;
        rs1   = 32'hFFFF_FFFF;
        rs2   = 32'h7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {63'b0, busy}, 64'h0);
        check("mrst_done", {63'b0, done}, 64'h0);
        check("mrst_res", {32'b0, res}, 64'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("mrst_nopulse", 64'(n_done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
